// File: rtl/decode_pkg.sv
// Shared widths and the ID/EX payload carried by the decode stage.
package decode_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rs1_data;
    logic [DEF_DATA_W-1:0] rs2_data;
    logic [DEF_ADDR_W-1:0] rd;
    logic                  rd_we;
  } id_ex_t;
endpackage

// File: rtl/reg_file_fwd.sv
// Architectural register file with two read ports forwarding same-cycle write-back.
module reg_file_fwd
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_W,
  parameter int DATA_WIDTH  = DEF_DATA_W,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_ok;

  assign wr_ok = wb_en && !(ZERO_REG_EN && wb_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // x0 check precedes forwarding so a write-back to x0 never leaks through
  assign rs1_data = (ZERO_REG_EN && rs1 == '0)    ? '0      :
                    (wb_en && wb_addr == rs1)      ? wb_data : regs[rs1];
  assign rs2_data = (ZERO_REG_EN && rs2 == '0)    ? '0      :
                    (wb_en && wb_addr == rs2)      ? wb_data : regs[rs2];
endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage: register read with forwarding, pending-bit scoreboard for RAW/WAW
// stalls, and an ID/EX output register with valid/ready handshake and flush.
module decode_stage_sb
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_W,
  parameter int DATA_WIDTH  = DEF_DATA_W,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_we
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic [NUM_REGS-1:0]   pend, pend_nxt, eff_pend, wb_hot;
  logic                  hazard, space, accept, set_ok;
  id_ex_t                id_ex;

  reg_file_fwd #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_REG_EN(ZERO_REG_EN)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .rs1_data(rs1_val),
    .rs2_data(rs2_val)
  );

  // A write-back landing this cycle resolves its hazard in the same cycle
  assign wb_hot   = wb_en ? (NUM_REGS'(1) << wb_addr) : '0;
  assign eff_pend = pend & ~wb_hot;
  assign hazard   = eff_pend[in_rs1] || eff_pend[in_rs2] || (in_rd_we && eff_pend[in_rd]);
  assign space    = !out_valid || out_ready || flush;
  assign in_ready = space && !hazard;
  assign accept   = in_valid && in_ready;
  assign set_ok   = in_rd_we && !(ZERO_REG_EN && in_rd == '0);

  // Later assignments win, so a new reservation overrides a same-register clear
  always_comb begin
    pend_nxt = pend;
    if (wb_en) pend_nxt[wb_addr] = 1'b0;
    if (flush && out_valid && id_ex.rd_we) pend_nxt[id_ex.rd] = 1'b0;
    if (accept && set_ok) pend_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      id_ex     <= '0;
    end else begin
      pend <= pend_nxt;
      if (accept) begin
        out_valid      <= 1'b1;
        id_ex.rs1_data <= rs1_val;
        id_ex.rs2_data <= rs2_val;
        id_ex.rd       <= in_rd;
        id_ex.rd_we    <= in_rd_we;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_rs1_data = id_ex.rs1_data;
  assign out_rs2_data = id_ex.rs2_data;
  assign out_rd       = id_ex.rd;
  assign out_rd_we    = id_ex.rd_we;
endmodule

// File: tb/tb_decode_stage_sb.sv
// Scenario bench for decode_stage_sb with a scoreboard of expected ID/EX payloads.
module tb_decode_stage_sb;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_rd_we, wb_en, flush, out_valid, out_ready, out_rd_we;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_addr, out_rd;
  logic [31:0] wb_data, out_rs1_data, out_rs2_data;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_regs [32];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_sb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // Scoreboard: push on accept, pop when the output register retires or is flushed
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      if (out_valid && (out_ready || flush)) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_underflow: out_valid with empty queue, rd=%0d", out_rd);
        end else begin
          e = sbq.pop_front();
          if (!flush) begin
            n_cmp++;
            if ({out_rs1_data, out_rs2_data, out_rd, out_rd_we} !== {e.a, e.b, e.rd, e.we}) begin
              n_fail++;
              $display("FAIL sb_payload: got %h %h rd=%0d we=%b want %h %h rd=%0d we=%b",
                       out_rs1_data, out_rs2_data, out_rd, out_rd_we, e.a, e.b, e.rd, e.we);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        e.a = mread(in_rs1); e.b = mread(in_rs2); e.rd = in_rd; e.we = in_rd_we;
        sbq.push_back(e);
      end
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic we);
    in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_we = we;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0); set_wb(0, 0, 0);
    step(); step(); #2;
    n_cmp++;
    if ({out_valid, out_rd_we, out_rd, out_rs1_data, out_rs2_data} !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b we=%b rd=%0d %h %h want all zero",
               out_valid, out_rd_we, out_rd, out_rs1_data, out_rs2_data);
    end
    step(); rst = 1'b0; #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_wb_read();
    set_wb(1, 3, 32'hDEADBEEF); step();
    set_wb(0, 0, 0); set_in(1, 3, 0, 1, 0); #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wbread_ready: got %b want 1", in_ready); end
    step(); set_in(0, 0, 0, 0, 0); #2;
    n_cmp++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wbread_latency: got v=%b %h want v=1 deadbeef", out_valid, out_rs1_data);
    end
    step();
  endtask

  task automatic test_fwd();
    set_wb(1, 5, 32'h1234); set_in(1, 0, 5, 2, 0); #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: got %b want 1", in_ready); end
    step(); set_wb(0, 0, 0); set_in(0, 0, 0, 0, 0); #2;
    n_cmp++;
    if (out_rs2_data !== 32'h1234) begin
      n_fail++; $display("FAIL fwd_rs2: got %h want 00001234", out_rs2_data);
    end
    step();
  endtask

  task automatic test_raw();
    set_in(1, 0, 0, 7, 1); step();
    set_in(1, 7, 0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      #2; n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    set_wb(1, 7, 32'hA5A50007); #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", in_ready); end
    step(); set_wb(0, 0, 0); set_in(0, 0, 0, 0, 0); #2;
    n_cmp++;
    if (out_rs1_data !== 32'hA5A50007) begin
      n_fail++; $display("FAIL raw_operand: got %h want a5a50007", out_rs1_data);
    end
    step();
  endtask

  task automatic test_x0();
    set_wb(1, 0, 32'hFFFFFFFF); set_in(1, 0, 0, 0, 1); #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready0: got %b want 1", in_ready); end
    step(); set_wb(0, 0, 0); set_in(1, 0, 0, 4, 1); #2;
    n_cmp++;
    if (in_ready !== 1'b1 || out_rs1_data !== 32'h0) begin
      n_fail++; $display("FAIL x0_nostall: got rdy=%b %h want rdy=1 0", in_ready, out_rs1_data);
    end
    step(); set_in(0, 0, 0, 0, 0); #2;
    n_cmp++;
    if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin
      n_fail++; $display("FAIL x0_read: got %h %h want 0 0", out_rs1_data, out_rs2_data);
    end
    set_wb(1, 4, 32'h44); step(); set_wb(0, 0, 0);
  endtask

  task automatic test_backpressure_flush();
    out_ready = 1'b0;
    set_in(1, 3, 0, 9, 1); step();
    set_in(1, 1, 0, 2, 1);
    for (int i = 0; i < 3; i++) begin
      #2; n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd9 || out_rs1_data !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b rd=%0d %h want 0 1 9 deadbeef",
                 i, in_ready, out_valid, out_rd, out_rs1_data);
      end
      step();
    end
    flush = 1'b1; #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    step(); flush = 1'b0; out_ready = 1'b1; set_in(1, 9, 0, 0, 0); #2;
    n_cmp++;
    if (in_ready !== 1'b1 || out_rd !== 5'd2) begin
      n_fail++; $display("FAIL flush_clear: got rdy=%b rd=%0d want 1 2", in_ready, out_rd);
    end
    step(); set_in(0, 0, 0, 0, 0);
    set_wb(1, 2, 32'h22); step(); set_wb(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_wb(1, 5'(10 + i), $urandom);
      set_in(1, 5'(10 + i), 5'(9 + i), 5'(20 + i), 0); #2;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      step();
    end
    set_wb(0, 0, 0); set_in(0, 0, 0, 0, 0); step(); step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_in(1, 3, 0, 9, 1); step();
    set_in(1, 9, 0, 0, 0); #2;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_stall: got rdy=%b v=%b want 0 1", in_ready, out_valid);
    end
    step(); set_in(0, 0, 0, 0, 0); rst = 1'b1; step(); rst = 1'b0; #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    out_ready = 1'b1; set_in(1, 9, 0, 0, 0); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    step(); set_in(0, 0, 0, 0, 0); #2;
    n_cmp++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'h0) begin
      n_fail++; $display("FAIL rmid_read: got v=%b %h want 1 0", out_valid, out_rs1_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_wb_read();
    test_fwd();
    test_raw();
    test_x0();
    test_backpressure_flush();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) step();
    n_cmp++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sbq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_sb.md
Name: decode_stage_sb

Overview:
- Pipelined successor to the single-cycle decode phase.
- Contains the architectural register file, with write-back-to-read forwarding and an optional hardwired-zero x0.
- Adds a per-register pending scoreboard for RAW/WAW stall detection and an ID/EX output register with valid/ready handshake and flush.
- Sits between fetch/decode field extraction and the execute stage.

Parameters:
ADDR_WIDTH, 5, register address width; register count NUM_REGS = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
ZERO_REG_EN, 1, 1 = register 0 reads as zero, ignores writes and is never marked pending

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream has a decoded instruction
in_ready  output  1  stage accepts instruction this cycle
in_rs1  input  ADDR_WIDTH  source 1 address
in_rs2  input  ADDR_WIDTH  source 2 address
in_rd  input  ADDR_WIDTH  destination address
in_rd_we  input  1  instruction writes rd
wb_en  input  1  write-back strobe
wb_addr  input  ADDR_WIDTH  write-back address
wb_data  input  DATA_WIDTH  write-back data
flush  input  1  kill instruction held in output register
out_valid  output  1  output register holds an instruction
out_ready  input  1  execute consumes output this cycle
out_rs1_data  output  DATA_WIDTH  source 1 operand
out_rs2_data  output  DATA_WIDTH  source 2 operand
out_rd  output  ADDR_WIDTH  destination address
out_rd_we  output  1  destination write enable

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset state: all registers 0, all pending bits 0, out_valid 0, out_rs1_data/out_rs2_data/out_rd 0, out_rd_we 0. Reset mid-operation discards the held instruction and any pending state.
- Register file write: on posedge, if wb_en (and not (ZERO_REG_EN && wb_addr==0)), then reg[wb_addr] <= wb_data.
- Read with forwarding: rsX_val = 0 if ZERO_REG_EN && rsX==0; else wb_data if wb_en && wb_addr==rsX; else reg[rsX].
- Effective pending: eff_pend[r] = pend[r] && !(wb_en && wb_addr==r).
- Hazard: hazard = eff_pend[in_rs1] || eff_pend[in_rs2] || (in_rd_we && eff_pend[in_rd]). The third term is a WAW stall, so one pending bit per register suffices.
- Output-register space: space = !out_valid || out_ready || flush.
- Ready/accept: in_ready = space && !hazard. in_ready is combinational and must not depend on in_valid. accept = in_valid && in_ready.
- Latency: on accept, the output register loads rs1_val, rs2_val, in_rd and in_rd_we, and out_valid = 1 the next cycle (1-cycle latency).
- Output update, when not accepting:
  - out_valid is cleared if out_ready or flush.
  - Otherwise the output holds stable (data must not change while out_valid && !out_ready).
- Pending-bit update, applied in this order per cycle:
  - Clear pend[wb_addr] on wb_en.
  - On flush with out_valid && out_rd_we, clear pend[out_rd].
  - On accept with in_rd_we and non-zero rd (or ZERO_REG_EN=0), set pend[in_rd].
  - Set wins over clear for the same register in the same cycle.
- Pending lifetime: the bit is set when the instruction enters the output register and remains set until its write-back. Downstream guarantees every instruction that leaves via out_ready eventually writes back or is cancelled by the pipeline owner.
- Flush and accept in the same cycle: the held instruction is dropped and the new instruction is loaded.
- No combinational path from out_ready to any output other than in_ready.

Decomposition:
- Shared package decode_pkg: default widths and the id_ex_t struct {rs1_data, rs2_data, rd, rd_we}.
- One sub-module, reg_file_fwd: register storage, two forwarded read ports, x0 handling.
- Scoreboard and handshake logic stay in the top module.

Test Plan:
- Reset then write-back (wb_en=1, wb_addr=3, wb_data=0xDEADBEEF), next cycle issue rs1=3 -> out_rs1_data=0xDEADBEEF one cycle after accept.
- Same-cycle forwarding: wb_en=1, wb_addr=5, wb_data=0x1234 while issuing rs2=5 -> out_rs2_data=0x1234.
- RAW stall: issue rd=7 in_rd_we=1, consume it, then issue rs1=7 -> in_ready=0 until wb_addr=7 is pulsed; in_ready=1 in that wb cycle and the operand equals wb_data.
- x0: wb_en to addr 0 with 0xFFFFFFFF, and an instruction with rd=0 in_rd_we=1 -> reads of x0 return 0 and never stall.
- Backpressure plus flush: out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then flush=1 with a new in_valid -> new instruction loaded, and the flushed rd's pending bit is cleared (a later read of it does not stall).
- Reset mid-stall: pend[9]=1 with an instruction held, assert rst -> out_valid=0 and a subsequent rs1=9 is accepted immediately, reading 0.
